// File: rtl/dma_controller_if.sv
// Bus bundle between the DMA engine, its control host and the shared memory port.
// The master modport is the DMA side; the slave modport is the host/memory side.
interface dma_controller_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_we_n;
  logic              mem_ce_n;
  logic              done;

  modport master (
    input  start, src_addr, dst_addr, mem_data_out,
    output mem_addr, mem_data_in, mem_we_n, mem_ce_n, done
  );

  modport slave (
    output start, src_addr, dst_addr, mem_data_out,
    input  mem_addr, mem_data_in, mem_we_n, mem_ce_n, done
  );
endinterface

// File: rtl/dma_controller.sv
// Single-byte memory-to-memory DMA: read src, write dst, pulse done.
// All outputs are Moore-decoded from registered state so reset deasserts them at once.
module dma_controller #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_controller_if.master    bus_io
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    src_d              = src_q;
    dst_d              = dst_q;
    data_d             = data_q;
    bus_io.mem_addr    = '0;
    bus_io.mem_data_in = '0;
    bus_io.mem_we_n    = 1'b1;
    bus_io.mem_ce_n    = 1'b1;
    bus_io.done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // start is only looked at here, so requests while busy are dropped
        if (bus_io.start) begin
          src_d   = bus_io.src_addr;
          dst_d   = bus_io.dst_addr;
          state_d = StRead;
        end
      end
      StRead: begin
        bus_io.mem_ce_n = 1'b0;
        bus_io.mem_addr = src_q;
        data_d          = bus_io.mem_data_out;
        state_d         = StWrite;
      end
      StWrite: begin
        bus_io.mem_ce_n    = 1'b0;
        bus_io.mem_we_n    = 1'b0;
        bus_io.mem_addr    = dst_q;
        bus_io.mem_data_in = data_q;
        state_d            = StDone;
      end
      StDone: begin
        bus_io.done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed plus randomized bench for dma_controller against a byte-array memory model.
module tb_dma_controller;

  logic clk;
  logic rst_n;

  dma_controller_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  dma_controller #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the DMA talks to, plus the expected contents kept by the bench.
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic       pl_en;
  logic [3:0] pl_a;
  logic [7:0] pl_d;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!bus.mem_ce_n && !bus.mem_we_n) mem[bus.mem_addr] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = mem[bus.mem_addr];

  int n_checks;
  int n_fail;
  int done_cnt;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en      = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".ce_n"}, 32'(bus.mem_ce_n), 32'd1);
    chk({tag, ".we_n"}, 32'(bus.mem_we_n), 32'd1);
    chk({tag, ".addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, ".wdata"}, 32'(bus.mem_data_in), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
  endtask

  // One transfer from IDLE: expected byte is whatever the model holds at src.
  task automatic transfer(input logic [3:0] src, input logic [3:0] dst,
                          input bit hold, input bit busy_poke);
    logic [7:0] exp;
    exp          = ref_mem[src];
    bus.start    = 1'b1;
    bus.src_addr = src;
    bus.dst_addr = dst;
    step();
    if (!hold) bus.start = 1'b0;
    chk("read.ce_n", 32'(bus.mem_ce_n), 32'd0);
    chk("read.we_n", 32'(bus.mem_we_n), 32'd1);
    chk("read.addr", 32'(bus.mem_addr), 32'(src));
    chk("read.done", 32'(bus.done), 32'd0);
    step();
    chk("write.ce_n", 32'(bus.mem_ce_n), 32'd0);
    chk("write.we_n", 32'(bus.mem_we_n), 32'd0);
    chk("write.addr", 32'(bus.mem_addr), 32'(dst));
    chk("write.wdata", 32'(bus.mem_data_in), 32'(exp));
    if (busy_poke) begin
      bus.start    = 1'b1;
      bus.src_addr = 4'h0;
      bus.dst_addr = 4'h1;
    end
    step();
    if (busy_poke) bus.start = 1'b0;
    ref_mem[dst] = exp;
    chk("done.done", 32'(bus.done), 32'd1);
    chk("done.ce_n", 32'(bus.mem_ce_n), 32'd1);
    chk("done.addr", 32'(bus.mem_addr), 32'd0);
    chk("done.mem", 32'(mem[dst]), 32'(exp));
    step();
    chk("idle.done", 32'(bus.done), 32'd0);
    chk("idle.ce_n", 32'(bus.mem_ce_n), 32'd1);
  endtask

  int         d0;
  logic [7:0] m1;
  logic [7:0] m15;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    done_cnt     = 0;
    pl_en        = 1'b0;
    pl_a         = '0;
    pl_d         = '0;
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    rst_n        = 1'b1;
    #2 rst_n     = 1'b0;
    repeat (2) step();
    chk_idle_outs("reset");
    for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom));
    rst_n = 1'b1;
    step();
    chk_idle_outs("post_reset");

    // Basic transfer
    preload(4'h5, 8'hAA);
    transfer(4'h5, 4'hA, 1'b0, 1'b0);
    chk("basic.memA", 32'(mem[4'hA]), 32'hAA);

    // start during WRITE must be dropped
    m1 = ref_mem[1];
    d0 = done_cnt;
    transfer(4'h2, 4'h4, 1'b0, 1'b1);
    step();
    chk("busy.ce_n", 32'(bus.mem_ce_n), 32'd1);
    step();
    chk("busy.mem1", 32'(mem[1]), 32'(m1));
    chk("busy.done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // Reset during WRITE suppresses the write
    preload(4'h3, 8'h55);
    preload(4'hF, 8'hC3);
    m15          = ref_mem[15];
    d0           = done_cnt;
    bus.start    = 1'b1;
    bus.src_addr = 4'h3;
    bus.dst_addr = 4'hF;
    step();
    bus.start = 1'b0;
    chk("abort.read_addr", 32'(bus.mem_addr), 32'h3);
    step();
    chk("abort.write_we", 32'(bus.mem_we_n), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outs("abort");
    step();
    chk("abort.memF", 32'(mem[15]), 32'(m15));
    #2 rst_n = 1'b1;
    repeat (4) step();
    chk("abort.no_done", 32'(done_cnt), 32'(d0));
    chk("abort.ce_n", 32'(bus.mem_ce_n), 32'd1);

    // Held start: back-to-back every 4 cycles, boundary addresses
    preload(4'hF, 8'h3C);
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) transfer(4'hF, 4'h0, 1'b1, 1'b0);
    bus.start = 1'b0;
    step();
    chk("held.mem0", 32'(mem[0]), 32'h3C);
    chk("held.done_cnt", 32'(done_cnt), 32'(d0 + 3));

    // src == dst
    preload(4'h7, 8'h81);
    d0 = done_cnt;
    transfer(4'h7, 4'h7, 1'b0, 1'b0);
    step();
    chk("same.mem7", 32'(mem[7]), 32'h81);
    chk("same.done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // Randomized transfers
    for (int k = 0; k < 20; k++) begin
      transfer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) chk("final.mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
